// File: rtl/mips_cpu_harvard_fetch.sv
// Instruction-fetch stage for the Harvard MIPS CPU: owns the PC, delay-slot
// sequencing, halt-on-jump-to-HALT_ADDR and misaligned-target fault detection.
module mips_cpu_harvard_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] instr_word,
  output logic        instr_valid,
  output logic [31:0] pc_current,
  output logic [31:0] pc_link,
  output logic        in_delay_slot,
  output logic        fetch_fault,
  output logic        active
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pending_target, pending_next;
  logic        fault, fault_next;
  logic        running;
  logic        advance;

  assign running = (state == RUN) || (state == DELAY);
  assign advance = clk_enable & ~stall & running;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      pending_target <= 32'd0;
      fault          <= 1'b0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      pending_target <= pending_next;
      fault          <= fault_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_target;
    fault_next   = fault;
    if (advance) begin
      unique case (state)
        RUN: begin
          if (!branch_taken) begin
            pc_next = pc + 32'd4;
          end else if (branch_target[1:0] == 2'b00) begin
            pending_next = branch_target;
            pc_next      = pc + 32'd4;
            state_next   = DELAY;
          end else begin
            // Misaligned target: freeze the PC on the offending branch.
            fault_next = 1'b1;
            state_next = FAULT;
          end
        end
        DELAY: begin
          // A branch sitting in the delay slot is deliberately ignored.
          if (pending_target == HALT_ADDR) begin
            pc_next    = HALT_ADDR;
            state_next = HALTED;
          end else begin
            pc_next    = pending_target;
            state_next = RUN;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  assign instr_address = pc;
  assign pc_current    = pc;
  assign pc_link       = pc + 32'd8;
  assign instr_word    = running ? instr_readdata : 32'd0;
  assign instr_valid   = advance;
  assign in_delay_slot = (state == DELAY);
  assign fetch_fault   = fault;
  assign active        = running;

endmodule

// File: tb/tb_mips_cpu_harvard_fetch.sv
// Bench for mips_cpu_harvard_fetch: a vector table, directed multi-cycle
// sequences, and random traffic checked against an address-queue model.
module tb_mips_cpu_harvard_fetch;

  logic        clk = 1'b0;
  logic        reset, clk_enable, stall, branch_taken;
  logic [31:0] branch_target, instr_readdata;
  logic [31:0] instr_address, instr_word, pc_current, pc_link;
  logic        instr_valid, in_delay_slot, fetch_fault, active;

  int n_cmp = 0;
  int n_bad = 0;

  mips_cpu_harvard_fetch dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .instr_word(instr_word), .instr_valid(instr_valid),
    .pc_current(pc_current), .pc_link(pc_link),
    .in_delay_slot(in_delay_slot), .fetch_fault(fetch_fault), .active(active)
  );

  always #5 clk = ~clk;

  // Reference model: current PC, a queue of addresses the next advance must
  // jump to (the branch target, queued while the delay slot executes), and
  // two terminal flags.
  logic [31:0] m_pc = 32'hBFC00000;
  logic [31:0] m_jump_q[$];
  bit          m_halted = 0;
  bit          m_fault = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input logic r, e, s, b, input logic [31:0] t, d);
    reset = r; clk_enable = e; stall = s; branch_taken = b;
    branch_target = t; instr_readdata = d;
  endtask

  task automatic check_model();
    bit run;
    run = !m_halted && !m_fault;
    cmp("instr_address", instr_address, m_pc);
    cmp("pc_current", pc_current, m_pc);
    cmp("pc_link", pc_link, m_pc + 32'd8);
    cmp("instr_word", instr_word, run ? instr_readdata : 32'd0);
    cmp("instr_valid", {31'd0, instr_valid}, {31'd0, clk_enable & ~stall & run});
    cmp("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, run && m_jump_q.size() != 0});
    cmp("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    cmp("active", {31'd0, active}, {31'd0, run});
  endtask

  task automatic clock_edge();
    logic [31:0] t;
    @(posedge clk);
    if (reset) begin
      m_pc = 32'hBFC00000; m_jump_q.delete(); m_halted = 0; m_fault = 0;
    end else if (clk_enable && !stall && !m_halted && !m_fault) begin
      if (m_jump_q.size() != 0) begin
        t = m_jump_q.pop_front();
        m_pc = t;
        if (t == 32'd0) m_halted = 1;
      end else if (branch_taken && branch_target[1:0] != 2'b00) begin
        m_fault = 1;
      end else begin
        if (branch_taken) m_jump_q.push_back(branch_target);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic step(input logic r, e, s, b, input logic [31:0] t);
    apply(r, e, s, b, t, $urandom);
    @(negedge clk);
    check_model();
    clock_edge();
  endtask

  typedef struct {
    logic r, e, s, b;
    logic [31:0] t, d;
    bit          chk;
    logic [31:0] addr, link, word;
    logic        vld, ids, act, flt;
  } vec_t;

  function automatic vec_t mk(logic r, e, s, b, logic [31:0] t, d, bit chk,
                              logic [31:0] addr, link, word, logic vld, ids, act, flt);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.b = b; v.t = t; v.d = d; v.chk = chk;
    v.addr = addr; v.link = link; v.word = word;
    v.vld = vld; v.ids = ids; v.act = act; v.flt = flt;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    // Outputs are checked before the edge on which the row's inputs act.
    tbl[0]  = mk(1,0,0,0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h0,        0,0,0,0);
    tbl[1]  = mk(0,1,0,0, 32'h0,        32'h11111111, 1, 32'hBFC00000, 32'hBFC00008, 32'h11111111, 1,0,1,0);
    tbl[2]  = mk(0,1,0,1, 32'hBFC00100, 32'h22222222, 1, 32'hBFC00004, 32'hBFC0000C, 32'h22222222, 1,0,1,0);
    tbl[3]  = mk(0,1,0,0, 32'h0,        32'h33333333, 1, 32'hBFC00008, 32'hBFC00010, 32'h33333333, 1,1,1,0);
    tbl[4]  = mk(0,1,0,0, 32'h0,        32'h44444444, 1, 32'hBFC00100, 32'hBFC00108, 32'h44444444, 1,0,1,0);
    tbl[5]  = mk(0,1,1,0, 32'h0,        32'h55555555, 1, 32'hBFC00104, 32'hBFC0010C, 32'h55555555, 0,0,1,0);
    tbl[6]  = mk(0,0,0,0, 32'h0,        32'h66666666, 1, 32'hBFC00104, 32'hBFC0010C, 32'h66666666, 0,0,1,0);
    tbl[7]  = mk(0,1,0,1, 32'hBFC00102, 32'h77777777, 1, 32'hBFC00104, 32'hBFC0010C, 32'h77777777, 1,0,1,0);
    tbl[8]  = mk(0,1,0,0, 32'h0,        32'h88888888, 1, 32'hBFC00104, 32'hBFC0010C, 32'h0,        0,0,0,1);
    tbl[9]  = mk(1,0,0,0, 32'h0,        32'h99999999, 1, 32'hBFC00104, 32'hBFC0010C, 32'h0,        0,0,0,1);
    tbl[10] = mk(0,1,0,0, 32'h0,        32'hAAAAAAAA, 1, 32'hBFC00000, 32'hBFC00008, 32'hAAAAAAAA, 1,0,1,0);

    apply(1, 0, 0, 0, 32'd0, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].b, tbl[i].t, tbl[i].d);
      @(negedge clk);
      if (tbl[i].chk) begin
        cmp($sformatf("tbl%0d.addr", i), instr_address, tbl[i].addr);
        cmp($sformatf("tbl%0d.pc", i), pc_current, tbl[i].addr);
        cmp($sformatf("tbl%0d.link", i), pc_link, tbl[i].link);
        cmp($sformatf("tbl%0d.word", i), instr_word, tbl[i].word);
        cmp($sformatf("tbl%0d.valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].vld});
        cmp($sformatf("tbl%0d.delay", i), {31'd0, in_delay_slot}, {31'd0, tbl[i].ids});
        cmp($sformatf("tbl%0d.active", i), {31'd0, active}, {31'd0, tbl[i].act});
        cmp($sformatf("tbl%0d.fault", i), {31'd0, fetch_fault}, {31'd0, tbl[i].flt});
      end
      clock_edge();
    end

    // Jump to address 0 from 0xBFC00010, delay slot at 0x14, then halted.
    step(1, 0, 0, 0, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 32'd0);
    step(0, 1, 0, 1, 32'h00000000);
    cmp("halt.slot_addr", instr_address, 32'hBFC00014);
    step(0, 1, 0, 0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cmp("halt.addr", instr_address, 32'h0);
      cmp("halt.active", {31'd0, active}, 32'd0);
      step(0, 1, 0, $urandom_range(0, 1), 32'hBFC00000);
    end

    // Stall and clock-enable holds inside a delay slot and in RUN.
    step(1, 0, 0, 0, 32'd0);
    step(0, 1, 0, 0, 32'd0);
    step(0, 1, 0, 1, 32'hBFC00200);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 32'h00000000);
    step(0, 0, 0, 0, 32'd0);
    step(0, 1, 0, 0, 32'd0);
    cmp("stall.target", instr_address, 32'hBFC00200);
    step(0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 1, 32'hBFC00400);
    step(0, 1, 0, 0, 32'd0);
    cmp("en.resume", instr_address, 32'hBFC00204);

    // Reset while in a delay slot with the clock disabled discards the target.
    step(0, 1, 0, 1, 32'hBFC00300);
    step(1, 0, 0, 0, 32'd0);
    cmp("rst_delay.pc", instr_address, 32'hBFC00000);
    step(0, 1, 0, 0, 32'd0);
    step(0, 1, 0, 0, 32'd0);
    cmp("rst_delay.no_target", instr_address, 32'hBFC00008);

    // PC wraps past 0xFFFFFFFC to 0 without halting.
    step(0, 1, 0, 1, 32'hFFFFFFF8);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 32'd0);
    cmp("wrap.addr", instr_address, 32'h00000004);
    cmp("wrap.active", {31'd0, active}, 32'd1);

    // Random traffic against the model.
    step(1, 0, 0, 0, 32'd0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      int k;
      k = $urandom_range(0, 15);
      t = $urandom;
      if (k == 0) t = 32'd0;
      else if (k == 1) t[1:0] = 2'($urandom_range(1, 3));
      else t[1:0] = 2'b00;
      step($urandom_range(0, 29) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
